varint_decode_0: RTL and testbench

Downstream consumer of the varint input FIFO pair (data + index) filled by the AXI4 write-slave FSM. The block pops 32-bit words and scans them byte by byte, least-significant byte first. It reassembles one protobuf-style base-128 varint per index value and presents the decoded 64-bit value, tagged with its index, on a valid/ready output port. Truncated and overlong varints are flagged, and their errors are counted.

---
 rtl/varint_decode_0.sv | 189 ++++++++++++++++++
 tb/tb_varint_decode_0.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/varint_decode_0.sv
// varint_decode_0: pops 32-bit words from a show-ahead data/index FIFO pair,
// scans them least-significant byte first and reassembles one base-128 varint
// per index value. Results leave on a valid/ready port with truncation and
// overflow flags plus a saturating error counter.
module varint_decode_0 #(
    parameter int IDX_W     = 10,
    parameter int MAX_BYTES = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             varint_in_fifo_clr,
    input  logic             varint_in_fifo_empty,
    input  logic [31:0]      varint_in_fifo_data,
    input  logic [IDX_W-1:0] varint_in_index_data,
    output logic             varint_in_fifo_pop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_value,
    output logic [IDX_W-1:0] out_index,
    output logic [3:0]       out_len,
    output logic             out_err_trunc,
    output logic             out_err_ovf,
    output logic [15:0]      err_count
);

    typedef enum logic [2:0] {IDLE, SCAN, FETCH, EMIT, SKIP} state_t;

    localparam logic [3:0] MAX_LEN = 4'(MAX_BYTES);

    state_t state, state_next;

    logic [31:0]      word_q, word_d;
    logic [1:0]       sel, sel_d;
    logic [63:0]      acc, acc_d;
    logic [3:0]       nbytes, nbytes_d;
    logic [IDX_W-1:0] cur_idx, cur_idx_d;

    logic             valid_d, trunc_d, ovf_d;
    logic [63:0]      value_d;
    logic [IDX_W-1:0] index_d;
    logic [3:0]       len_d;

    // Byte under the scan pointer and its 7 payload bits placed at 7*nbytes;
    // shifts past bit 63 fall off, so the 10th byte only contributes bit 0.
    logic [7:0]  cur_byte;
    logic [6:0]  shamt;
    logic [63:0] acc_scan;
    logic [3:0]  nbytes_inc;
    logic        same_idx;
    logic        handshake;

    assign cur_byte   = word_q[{sel, 3'b000} +: 8];
    assign shamt      = 7'(nbytes) * 7'd7;
    assign acc_scan   = acc | ({57'd0, cur_byte[6:0]} << shamt);
    assign nbytes_inc = nbytes + 4'd1;
    assign same_idx   = (varint_in_index_data == cur_idx);
    assign handshake  = out_valid && out_ready;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: registers are updated with non-blocking assignments so every
        // flop samples the pre-edge values regardless of block ordering.
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state, FIFO pop and next values of the datapath/result registers.
    always_comb begin
        // NOTE: every signal gets its hold value first, so no branch can leave
        // one unassigned and infer a latch.
        state_next         = state;
        varint_in_fifo_pop = 1'b0;
        word_d             = word_q;
        sel_d              = sel;
        acc_d              = acc;
        nbytes_d           = nbytes;
        cur_idx_d          = cur_idx;
        valid_d            = out_valid;
        value_d            = out_value;
        index_d            = out_index;
        len_d              = out_len;
        trunc_d            = out_err_trunc;
        ovf_d              = out_err_ovf;

        if (varint_in_fifo_clr) begin
            // Abort wins everywhere: drop partial work and any pending result.
            state_next = IDLE;
            valid_d    = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!varint_in_fifo_empty) begin
                        varint_in_fifo_pop = 1'b1;
                        word_d             = varint_in_fifo_data;
                        cur_idx_d          = varint_in_index_data;
                        sel_d              = 2'd0;
                        acc_d              = '0;
                        nbytes_d           = 4'd0;
                        state_next         = SCAN;
                    end
                end
                SCAN: begin
                    acc_d    = acc_scan;
                    nbytes_d = nbytes_inc;
                    if (!cur_byte[7] || nbytes_inc == MAX_LEN) begin
                        state_next = EMIT;
                        valid_d    = 1'b1;
                        value_d    = acc_scan;
                        index_d    = cur_idx;
                        len_d      = nbytes_inc;
                        trunc_d    = 1'b0;
                        ovf_d      = cur_byte[7];
                    end else if (sel == 2'd3) begin
                        state_next = FETCH;
                    end else begin
                        sel_d = sel + 2'd1;
                    end
                end
                FETCH: begin
                    if (!varint_in_fifo_empty) begin
                        if (same_idx) begin
                            varint_in_fifo_pop = 1'b1;
                            word_d             = varint_in_fifo_data;
                            sel_d              = 2'd0;
                            state_next         = SCAN;
                        end else begin
                            // Head word belongs to the next varint; leave it queued.
                            state_next = EMIT;
                            valid_d    = 1'b1;
                            value_d    = acc;
                            index_d    = cur_idx;
                            len_d      = nbytes;
                            trunc_d    = 1'b1;
                            ovf_d      = 1'b0;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        valid_d    = 1'b0;
                        state_next = out_err_ovf ? SKIP : IDLE;
                    end
                end
                SKIP: begin
                    // Discard the remaining words of an overlong varint.
                    if (!varint_in_fifo_empty) begin
                        if (same_idx) varint_in_fifo_pop = 1'b1;
                        else          state_next         = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Datapath, result and error-counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_q        <= '0;
            sel           <= '0;
            acc           <= '0;
            nbytes        <= '0;
            cur_idx       <= '0;
            out_valid     <= 1'b0;
            out_value     <= '0;
            out_index     <= '0;
            out_len       <= '0;
            out_err_trunc <= 1'b0;
            out_err_ovf   <= 1'b0;
            err_count     <= '0;
        end else begin
            word_q        <= word_d;
            sel           <= sel_d;
            acc           <= acc_d;
            nbytes        <= nbytes_d;
            cur_idx       <= cur_idx_d;
            out_valid     <= valid_d;
            out_value     <= value_d;
            out_index     <= index_d;
            out_len       <= len_d;
            out_err_trunc <= trunc_d;
            out_err_ovf   <= ovf_d;
            // An accepted result counts even if an abort arrives in the same cycle.
            if (handshake && (out_err_trunc || out_err_ovf) && err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_varint_decode_0.sv
// tb_varint_decode_0: drives varint_decode_0 from a model show-ahead FIFO,
// keeps a queue of expected results and compares each accepted output.
module tb_varint_decode_0;

    localparam int IDX_W = 10;

    typedef struct packed {
        logic [63:0]      value;
        logic [IDX_W-1:0] index;
        logic [3:0]       len;
        logic             trunc;
        logic             ovf;
    } res_t;

    typedef struct packed {
        logic [31:0]      word;
        logic [IDX_W-1:0] index;
        logic [63:0]      value;
        logic [3:0]       len;
    } vec_t;

    logic             clk;
    logic             reset_n;
    logic             fifo_clr;
    logic             fifo_empty;
    logic [31:0]      fifo_data;
    logic [IDX_W-1:0] fifo_idx;
    logic             pop;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_value;
    logic [IDX_W-1:0] out_index;
    logic [3:0]       out_len;
    logic             out_err_trunc;
    logic             out_err_ovf;
    logic [15:0]      err_count;

    varint_decode_0 #(.IDX_W(IDX_W), .MAX_BYTES(10)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .varint_in_fifo_clr   (fifo_clr),
        .varint_in_fifo_empty (fifo_empty),
        .varint_in_fifo_data  (fifo_data),
        .varint_in_index_data (fifo_idx),
        .varint_in_fifo_pop   (pop),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .out_value            (out_value),
        .out_index            (out_index),
        .out_len              (out_len),
        .out_err_trunc        (out_err_trunc),
        .out_err_ovf          (out_err_ovf),
        .err_count            (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Show-ahead FIFO model; an abort also flushes it.
    logic [31:0]      fmem [256];
    logic [IDX_W-1:0] imem [256];
    logic [7:0]       wr_ptr = 8'd0;
    logic [7:0]       rd_ptr = 8'd0;

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_data  = fmem[rd_ptr];
    assign fifo_idx   = imem[rd_ptr];

    always @(posedge clk) begin
        if (fifo_clr)  rd_ptr <= wr_ptr;
        else if (pop)  rd_ptr <= rd_ptr + 8'd1;
    end

    res_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   npops = 0;
    int   last_pop_cyc = 0;
    int   first_valid_cyc = 0;
    logic valid_rise = 1'b0;
    logic prev_valid = 1'b0;
    int   exp_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [31:0] w, input logic [IDX_W-1:0] i);
        fmem[wr_ptr] = w;
        imem[wr_ptr] = i;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic expect_res(input logic [63:0] v, input logic [IDX_W-1:0] i,
                              input logic [3:0] l, input logic t, input logic o);
        res_t r;
        r.value = v; r.index = i; r.len = l; r.trunc = t; r.ovf = o;
        exp_q.push_back(r);
        if (t || o) exp_err++;
    endtask

    // One clock: observe at the falling edge, return just after the rising edge.
    task automatic step();
        res_t r;
        @(negedge clk);
        cyc++;
        check("pop_when_empty", 64'(pop && fifo_empty), 64'd0);
        if (pop) begin
            npops++;
            last_pop_cyc = cyc;
        end
        if (out_valid && !prev_valid) begin
            valid_rise      = 1'b1;
            first_valid_cyc = cyc;
        end
        prev_valid = out_valid;
        if (out_valid && out_ready) begin
            check("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                r = exp_q.pop_front();
                check("value", out_value, r.value);
                check("index", 64'(out_index), 64'(r.index));
                check("len",   64'(out_len),   64'(r.len));
                check("trunc", 64'(out_err_trunc), 64'(r.trunc));
                check("ovf",   64'(out_err_ovf),   64'(r.ovf));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        valid_rise = 1'b0;
        while (!valid_rise && n < budget) begin
            step();
            n++;
        end
        check("valid_seen", 64'(valid_rise), 64'd1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || out_valid || !fifo_empty) && n < budget) begin
            step();
            n++;
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
        step();
        step();
    endtask

    vec_t vecs[7];
    logic [63:0] ovf_val;
    int pops_before;

    initial begin
        // Single-word varints: {word, index, value, len}; latency is len+1 from the pop.
        vecs[0] = '{32'hAAAAAA05, 10'd3,   64'd5,          4'd1};
        vecs[1] = '{32'h000002AC, 10'd9,   64'd300,        4'd2};
        vecs[2] = '{32'h0000007F, 10'd10,  64'd127,        4'd1};
        vecs[3] = '{32'h7FFFFFFF, 10'd11,  64'h0FFFFFFF,   4'd4};
        vecs[4] = '{32'h00000000, 10'd0,   64'd0,          4'd1};
        vecs[5] = '{32'h12345601, 10'h3FF, 64'd1,          4'd1};
        vecs[6] = '{32'h00018080, 10'd5,   64'd16384,      4'd3};

        reset_n   = 1'b0;
        fifo_clr  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_value", out_value, 64'd0);
        check("rst_len",   64'(out_len), 64'd0);
        check("rst_errc",  64'(err_count), 64'd0);
        check("rst_pop",   64'(pop), 64'd0);
        reset_n = 1'b1;
        step();

        // Table of single-word varints with latency check.
        for (int i = 0; i < 7; i++) begin
            push(vecs[i].word, vecs[i].index);
            expect_res(vecs[i].value, vecs[i].index, vecs[i].len, 1'b0, 1'b0);
            wait_valid(40);
            check("latency", 64'(first_valid_cyc - last_pop_cyc), 64'(vecs[i].len) + 64'd1);
            drain(40);
        end

        // Cross-word varint: exactly two pops.
        pops_before = npops;
        push(32'h80808080, 10'd7);
        push(32'h00000001, 10'd7);
        expect_res(64'h10000000, 10'd7, 4'd5, 1'b0, 1'b0);
        drain(60);
        check("xword_pops", 64'(npops - pops_before), 64'd2);

        // Truncation: index changes before the terminator.
        push(32'h80808080, 10'd1);
        push(32'h00000001, 10'd2);
        expect_res(64'd0, 10'd1, 4'd4, 1'b1, 1'b0);
        expect_res(64'd1, 10'd2, 4'd1, 1'b0, 1'b0);
        drain(60);
        check("errc_trunc", 64'(err_count), 64'(exp_err));

        // Overflow: ten continuation bytes, fourth idx-4 word popped in SKIP.
        ovf_val = '0;
        for (int n = 0; n < 10; n++) ovf_val |= 64'd1 << (7 * n);
        pops_before = npops;
        for (int n = 0; n < 4; n++) push(32'h81818181, 10'd4);
        push(32'h00000002, 10'd5);
        expect_res(ovf_val, 10'd4, 4'd10, 1'b0, 1'b1);
        expect_res(64'd2, 10'd5, 4'd1, 1'b0, 1'b0);
        drain(100);
        check("ovf_pops", 64'(npops - pops_before), 64'd5);
        check("errc_ovf", 64'(err_count), 64'(exp_err));

        // Backpressure: outputs hold and nothing pops while out_ready is low.
        out_ready = 1'b0;
        push(32'h000002AC, 10'd20);
        push(32'h00000005, 10'd21);
        expect_res(64'd300, 10'd20, 4'd2, 1'b0, 1'b0);
        expect_res(64'd5, 10'd21, 4'd1, 1'b0, 1'b0);
        wait_valid(40);
        for (int n = 0; n < 5; n++) begin
            step();
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_value", out_value, 64'd300);
            check("bp_index", 64'(out_index), 64'd20);
            check("bp_len",   64'(out_len), 64'd2);
            check("bp_flags", 64'({out_err_trunc, out_err_ovf}), 64'd0);
            check("bp_pop",   64'(pop), 64'd0);
        end
        out_ready = 1'b1;
        drain(60);

        // Abort in IDLE with a word waiting: no pop in that cycle.
        fifo_clr = 1'b1;
        push(32'h00000009, 10'd25);
        #1;
        check("clr_idle_pop", 64'(pop), 64'd0);
        step();
        fifo_clr = 1'b0;

        // Abort mid-SCAN of a three-word varint; then a fresh varint decodes normally.
        push(32'h80808080, 10'd30);
        push(32'h80808080, 10'd30);
        push(32'h80808080, 10'd30);
        step();
        step();
        fifo_clr = 1'b1;
        step();
        fifo_clr = 1'b0;
        check("clr_scan_valid", 64'(out_valid), 64'd0);
        push(32'h00000005, 10'd31);
        expect_res(64'd5, 10'd31, 4'd1, 1'b0, 1'b0);
        wait_valid(40);
        check("clr_latency", 64'(first_valid_cyc - last_pop_cyc), 64'd2);
        drain(40);
        check("clr_errc", 64'(err_count), 64'(exp_err));

        // Abort during EMIT drops the pending result.
        out_ready = 1'b0;
        push(32'h00000005, 10'd40);
        wait_valid(40);
        fifo_clr = 1'b1;
        step();
        fifo_clr = 1'b0;
        check("clr_emit_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        drain(20);
        check("clr_emit_errc", 64'(err_count), 64'(exp_err));

        // Reset mid-EMIT clears all outputs at once.
        out_ready = 1'b0;
        push(32'h0000002A, 10'd50);
        wait_valid(40);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_value", out_value, 64'd0);
        check("arst_index", 64'(out_index), 64'd0);
        check("arst_len",   64'(out_len), 64'd0);
        check("arst_flags", 64'({out_err_trunc, out_err_ovf}), 64'd0);
        check("arst_errc",  64'(err_count), 64'd0);
        check("arst_pop",   64'(pop), 64'd0);
        exp_q.delete();
        exp_err = 0;
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        prev_valid = 1'b0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
